// File: rtl/elevator_pkg.sv
// elevator_pkg
// Shared types and helpers for the SCAN elevator controller.
//   state_t : FSM state encoding (fixed encodings, decoded by the drivers' debug taps)
//   dir_t   : travel direction register encoding
//   max_u   : constant helper used to size the shared timer
package elevator_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        DOOR_CLOSE = 3'b001,
        MOVE_DOWN  = 3'b010,
        MOVE_UP    = 3'b011,
        DOOR_OPEN  = 3'b111
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// elevator_req_scan
// Combinational look-ahead for the SCAN decision: reports whether any request
// is pending strictly above or strictly below the cabin.
// Ports:
//   pending     in  N_FLOORS : request bitmap
//   etaj_curent in  FLOOR_W  : cabin floor
//   above       out 1        : some pending floor > etaj_curent
//   below       out 1        : some pending floor < etaj_curent
module elevator_req_scan #(
    parameter int unsigned N_FLOORS = 8,
    parameter int unsigned FLOOR_W  = $clog2(N_FLOORS)
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]  etaj_curent,
    output logic                above,
    output logic                below
);

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (i > 32'(etaj_curent))) begin
                above = 1'b1;
            end
            if (pending[i] && (i < 32'(etaj_curent))) begin
                below = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl
// SCAN (collective) elevator controller: keeps a pending-request bitmap, keeps
// travelling in one direction while requests remain ahead, and owns the door
// timer, the per-floor travel timer (one shared counter) and the cabin floor.
// Ports:
//   clk         in  1        : clock
//   reset       in  1        : synchronous, active-high; cabin position forced to 0
//   req_valid   in  1        : request strobe
//   req_floor   in  FLOOR_W  : requested floor, values >= N_FLOORS ignored
//   obstruct    in  1        : door obstruction sensor (level)
//   etaj_curent out FLOOR_W  : cabin floor (registered)
//   pending     out N_FLOORS : request bitmap (registered)
//   sus         out 1        : motor up   (MOVE_UP)
//   jos         out 1        : motor down (MOVE_DOWN)
//   door_status out 1        : door open  (DOOR_OPEN)
//   busy        out 1        : not idle, or requests outstanding
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS    = 8,
    parameter int unsigned FLOOR_W     = $clog2(N_FLOORS),
    parameter int unsigned DOOR_CYCLES = 4,
    parameter int unsigned MOVE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [FLOOR_W-1:0]  req_floor,
    input  logic                obstruct,
    output logic [FLOOR_W-1:0]  etaj_curent,
    output logic [N_FLOORS-1:0] pending,
    output logic                sus,
    output logic                jos,
    output logic                door_status,
    output logic                busy
);

    localparam int unsigned TIMER_MAX = max_u(DOOR_CYCLES, MOVE_CYCLES);
    localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0] DOOR_LAST = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] MOVE_LAST = TIMER_W'(MOVE_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);

    state_t              state_q, state_d;
    dir_t                dir_q, dir_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [FLOOR_W-1:0]  etaj_q, etaj_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;

    logic                above, below;
    logic                req_in_range, req_here, moving;
    logic                door_exp, move_exp;
    logic [FLOOR_W-1:0]  step_floor;
    logic [N_FLOORS-1:0] req_mask, step_mask;
    logic                step_hit;

    elevator_req_scan #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_req_scan (
        .pending     (pending_q),
        .etaj_curent (etaj_q),
        .above       (above),
        .below       (below)
    );

    // Request and timer decode.
    always_comb begin
        req_in_range = req_valid && (32'(req_floor) < N_FLOORS);
        req_here     = req_in_range && (req_floor == etaj_q);
        moving       = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
        door_exp     = (timer_q == DOOR_LAST);
        move_exp     = (timer_q == MOVE_LAST);
        // Only meaningful while moving; the assertion below guards the ends.
        step_floor   = (state_q == MOVE_UP) ? etaj_q + FLOOR_W'(1) : etaj_q - FLOOR_W'(1);
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            req_mask[i]  = req_in_range && (32'(req_floor) == i);
            step_mask[i] = (32'(step_floor) == i);
        end
        step_hit = |(pending_q & step_mask);
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        etaj_d    = etaj_q;
        timer_d   = timer_q + TIMER_W'(1);
        pending_d = pending_q;

        // A stationary cabin serves its own floor by (re)opening the door
        // instead of recording the request; a moving cabin records it.
        if (!(req_here && !moving)) begin
            pending_d = pending_q | req_mask;
        end

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (req_here) begin
                    state_d = DOOR_OPEN;
                end else if (pending_q != '0) begin
                    state_d = DOOR_CLOSE;
                end
            end

            DOOR_CLOSE: begin
                if (obstruct || req_here) begin
                    state_d = DOOR_OPEN;
                end else if (door_exp) begin
                    // Keep going up while work remains above; otherwise
                    // prefer down, and only then turn back up.
                    if ((dir_q == DIR_UP) && above) begin
                        state_d = MOVE_UP;
                    end else if (below) begin
                        state_d = MOVE_DOWN;
                        dir_d   = DIR_DOWN;
                    end else if (above) begin
                        state_d = MOVE_UP;
                        dir_d   = DIR_UP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            MOVE_UP, MOVE_DOWN: begin
                if (move_exp) begin
                    etaj_d  = step_floor;
                    timer_d = '0;
                    if (step_hit) begin
                        // Clearing after the set makes a same-edge request
                        // for the arrival floor count as served.
                        pending_d = pending_d & ~step_mask;
                        state_d   = DOOR_OPEN;
                    end
                end
            end

            DOOR_OPEN: begin
                if (req_here || obstruct) begin
                    timer_d = '0;
                end else if (door_exp) begin
                    state_d = (pending_q != '0) ? DOOR_CLOSE : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            timer_q   <= '0;
            etaj_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            timer_q   <= timer_d;
            etaj_q    <= etaj_d;
            pending_q <= pending_d;
        end
    end

    // SCAN only moves toward a pending floor, so the cabin can never step
    // past either end of the shaft.
    always_ff @(posedge clk) begin
        if (!reset && move_exp) begin
            if (state_q == MOVE_UP) begin
                a_no_step_above_top: assert (etaj_q != TOP_FLOOR);
            end
            if (state_q == MOVE_DOWN) begin
                a_no_step_below_zero: assert (etaj_q != '0);
            end
        end
    end

    assign etaj_curent = etaj_q;
    assign pending     = pending_q;
    assign sus         = (state_q == MOVE_UP);
    assign jos         = (state_q == MOVE_DOWN);
    assign door_status = (state_q == DOOR_OPEN);
    assign busy        = (state_q != IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl. FLOOR_W is widened to 4 so that floors
// >= N_FLOORS can be requested. Every door opening is matched against a
// queue of expected arrival floors; the first scenario also checks a
// per-cycle expected output timeline taken from a queue.
module tb_elevator_scan_ctrl;

    localparam int unsigned N_FLOORS    = 8;
    localparam int unsigned FLOOR_W     = 4;
    localparam int unsigned DOOR_CYCLES = 4;
    localparam int unsigned MOVE_CYCLES = 8;

    logic                clk       = 1'b0;
    logic                reset     = 1'b1;
    logic                req_valid = 1'b0;
    logic [FLOOR_W-1:0]  req_floor = '0;
    logic                obstruct  = 1'b0;
    logic [FLOOR_W-1:0]  etaj_curent;
    logic [N_FLOORS-1:0] pending;
    logic                sus, jos, door_status, busy;

    elevator_scan_ctrl #(
        .N_FLOORS    (N_FLOORS),
        .FLOOR_W     (FLOOR_W),
        .DOOR_CYCLES (DOOR_CYCLES),
        .MOVE_CYCLES (MOVE_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_floor   (req_floor),
        .obstruct    (obstruct),
        .etaj_curent (etaj_curent),
        .pending     (pending),
        .sus         (sus),
        .jos         (jos),
        .door_status (door_status),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                busy;
        logic                sus;
        logic                jos;
        logic                door;
        logic [FLOOR_W-1:0]  floor;
        logic [N_FLOORS-1:0] pend;
    } obs_t;

    obs_t        exp_q[$];
    int unsigned arr_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned exp_arr;
    logic        door_prev = 1'b0;
    int          cyc, jos_first, door6_end, dwell;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic post(input int unsigned f);
        req_valid = 1'b1;
        req_floor = FLOOR_W'(f);
    endtask

    task automatic check_obs(input string tag, input obs_t e);
        check_eq({tag, "_busy"},  32'(busy),        32'(e.busy));
        check_eq({tag, "_sus"},   32'(sus),         32'(e.sus));
        check_eq({tag, "_jos"},   32'(jos),         32'(e.jos));
        check_eq({tag, "_door"},  32'(door_status), 32'(e.door));
        check_eq({tag, "_floor"}, 32'(etaj_curent), 32'(e.floor));
        check_eq({tag, "_pend"},  32'(pending),     32'(e.pend));
    endtask

    task automatic wait_door_open(input string tag, input int budget);
        int n = 0;
        while (!door_status && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(door_status), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    // Expected timeline for a floor-2 request from floor 0 at cycle 0.
    function automatic obs_t exp_t1(input int t);
        obs_t e;
        e.busy  = (t >= 1 && t <= 25);
        e.sus   = (t >= 6 && t <= 21);
        e.jos   = 1'b0;
        e.door  = (t >= 22 && t <= 25);
        e.floor = (t < 14) ? 4'd0 : (t < 22) ? 4'd1 : 4'd2;
        e.pend  = (t >= 1 && t <= 21) ? 8'h04 : 8'h00;
        return e;
    endfunction

    // Every door opening must match the next expected arrival floor.
    always @(negedge clk) begin
        if (door_status && !door_prev) begin
            exp_arr = (arr_q.size() != 0) ? arr_q.pop_front() : 32'hFFFF_FFFF;
            check_eq("arrival_floor", 32'(etaj_curent), exp_arr);
        end
        door_prev <= door_status;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t e;

        // Reset values.
        reset = 1'b1;
        tick(3);
        check_eq("rst_floor", 32'(etaj_curent), 32'd0);
        check_eq("rst_pend",  32'(pending),     32'd0);
        check_eq("rst_sus",   32'(sus),         32'd0);
        check_eq("rst_jos",   32'(jos),         32'd0);
        check_eq("rst_door",  32'(door_status), 32'd0);
        check_eq("rst_busy",  32'(busy),        32'd0);

        // Cycle-exact single trip 0 -> 2.
        reset = 1'b0;
        post(2);
        arr_q.push_back(2);
        for (int t = 0; t <= 26; t++) begin
            exp_q.push_back(exp_t1(t));
        end
        for (int t = 0; t <= 26; t++) begin
            e = exp_q.pop_front();
            check_obs($sformatf("t1@%0d", t), e);
            @(negedge clk);
            req_valid = 1'b0;
        end

        // SCAN ordering: at floor 3 going up, requests 5, 1, 6.
        post(3);
        arr_q.push_back(3);
        tick(1);
        req_valid = 1'b0;
        wait_door_open("t2_reach3", 100);
        check_eq("t2_floor3", 32'(etaj_curent), 32'd3);
        arr_q.push_back(5);
        arr_q.push_back(6);
        arr_q.push_back(1);
        post(5);
        tick(1);
        post(1);
        tick(1);
        post(6);
        tick(1);
        req_valid = 1'b0;
        cyc       = 0;
        jos_first = -1;
        door6_end = -1;
        while (busy && cyc < 400) begin
            if (jos && jos_first < 0) jos_first = cyc;
            if (door_status && etaj_curent == 4'd6) door6_end = cyc;
            @(negedge clk);
            cyc++;
        end
        check_eq("t2_idle", 32'(busy), 32'd0);
        check_eq("t2_jos_after_dwell6", 32'(door6_end >= 0 && jos_first > door6_end), 32'd1);
        check_eq("t2_floor1", 32'(etaj_curent), 32'd1);
        check_eq("t2_pend", 32'(pending), 32'd0);

        // Obstruction: re-open from DOOR_CLOSE, then stretch the dwell.
        post(4);
        arr_q.push_back(1);
        arr_q.push_back(4);
        tick(1);
        req_valid = 1'b0;
        tick(1);
        check_eq("t3_closing_door", 32'(door_status), 32'd0);
        check_eq("t3_closing_busy", 32'(busy), 32'd1);
        tick(1);
        obstruct = 1'b1;
        tick(1);
        check_eq("t3_reopen", 32'(door_status), 32'd1);
        check_eq("t3_reopen_sus", 32'(sus), 32'd0);
        dwell = 0;
        while (door_status && dwell < 100) begin
            if (dwell == 10) obstruct = 1'b0;
            dwell++;
            @(negedge clk);
        end
        obstruct = 1'b0;
        check_eq("t3_dwell", 32'(dwell), 32'(10 + DOOR_CYCLES));
        wait_idle("t3_idle", 200);
        check_eq("t3_floor4", 32'(etaj_curent), 32'd4);

        // Current-floor request in IDLE, then again during DOOR_OPEN.
        post(4);
        arr_q.push_back(4);
        tick(1);
        req_valid = 1'b0;
        check_eq("t4_open", 32'(door_status), 32'd1);
        check_eq("t4_pend", 32'(pending), 32'd0);
        tick(1);
        post(4);
        tick(1);
        req_valid = 1'b0;
        tick(2);
        check_eq("t4_restart_t5", 32'(door_status), 32'd1);
        tick(1);
        check_eq("t4_restart_t6", 32'(door_status), 32'd1);
        tick(1);
        check_eq("t4_closed_t7", 32'(door_status), 32'd0);
        check_eq("t4_idle_t7", 32'(busy), 32'd0);
        check_eq("t4_pend_end", 32'(pending), 32'd0);

        // Out-of-range floors are ignored.
        post(N_FLOORS);
        tick(1);
        post(15);
        tick(1);
        req_valid = 1'b0;
        check_eq("t5_pend", 32'(pending), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_door", 32'(door_status), 32'd0);

        // Request for the arrival floor on the arrival edge stays cleared.
        post(6);
        arr_q.push_back(6);
        tick(1);
        req_valid = 1'b0;
        tick(20);
        check_eq("t6_sus_t21", 32'(sus), 32'd1);
        check_eq("t6_floor_t21", 32'(etaj_curent), 32'd5);
        check_eq("t6_pend_t21", 32'(pending), 32'h40);
        post(6);
        tick(1);
        post(6);
        check_eq("t6_door_t22", 32'(door_status), 32'd1);
        check_eq("t6_floor_t22", 32'(etaj_curent), 32'd6);
        check_eq("t6_pend_t22", 32'(pending), 32'd0);
        tick(1);
        req_valid = 1'b0;
        check_eq("t6_pend_t23", 32'(pending), 32'd0);
        wait_idle("t6_idle", 100);

        // Reset in the middle of MOVE_UP.
        post(7);
        tick(1);
        req_valid = 1'b0;
        tick(7);
        check_eq("t7_moving", 32'(sus), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("t7_floor", 32'(etaj_curent), 32'd0);
        check_eq("t7_sus",   32'(sus),         32'd0);
        check_eq("t7_jos",   32'(jos),         32'd0);
        check_eq("t7_door",  32'(door_status), 32'd0);
        check_eq("t7_busy",  32'(busy),        32'd0);
        check_eq("t7_pend",  32'(pending),     32'd0);
        tick(2);

        check_eq("arrivals_left", 32'(arr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_scan_ctrl.md
# elevator_scan_ctrl

Parametrised elevator controller for N floors. It keeps a bitmap of pending floor requests and serves them with SCAN (collective) ordering, holding its direction while requests remain ahead. It integrates the door timer, the per-floor travel timer and the cabin position counter, and adds door re-open on obstruction. It sits between the floor-button/keypad decoder and the motor/door drivers, and the display logic reads its floor output.

## Interface
- `N_FLOORS`, 8: number of floors, ≥2.
- `FLOOR_W`, $clog2(N_FLOORS): floor index width.
- `DOOR_CYCLES`, 4: cycles per door phase (closing, open dwell), ≥1.
- `MOVE_CYCLES`, 8: cycles to travel one floor, ≥1.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request strobe, one per cycle.
- `req_floor` in FLOOR_W: requested floor. Values ≥N_FLOORS are ignored.
- `obstruct` in 1: door obstruction sensor, level.
- `etaj_curent` out FLOOR_W: cabin floor, registered.
- `pending` out N_FLOORS: request bitmap, registered.
- `sus` out 1: motor up.
- `jos` out 1: motor down.
- `door_status` out 1: 1 = door open.
- `busy` out 1: state ≠ IDLE or `pending` ≠ 0.

## Operation
- States are IDLE, DOOR_CLOSE, MOVE_UP, MOVE_DOWN and DOOR_OPEN. Outputs are Moore, decoded from the state register:
  - `sus`=1 only in MOVE_UP.
  - `jos`=1 only in MOVE_DOWN.
  - `door_status`=1 only in DOOR_OPEN.
- The internal timer clears on every state entry. A state "expires" when the timer reaches limit−1.
- Request capture: a valid, in-range `req_valid` sets `pending[req_floor]` on the next edge, except in the cases below:
  - Request for `etaj_curent` while in IDLE, DOOR_OPEN or DOOR_CLOSE: the bit is not set. Instead:
    - IDLE goes to DOOR_OPEN.
    - DOOR_OPEN restarts its timer.
    - DOOR_CLOSE goes to DOOR_OPEN.
  - Request for `etaj_curent` while moving: the bit is set and the floor is served later.
- Direction register `dir` (UP/DOWN), resets to UP. At DOOR_CLOSE expiry:
  - `above` = any pending bit > `etaj_curent`; `below` = any pending bit < `etaj_curent`.
  - If `dir`=UP and `above`, go to MOVE_UP.
  - Otherwise, if `below`, go to MOVE_DOWN and set `dir`=DOWN.
  - Otherwise, if `above`, go to MOVE_UP and set `dir`=UP.
  - Otherwise go to IDLE.
- IDLE: if `pending`≠0, go to DOOR_CLOSE.
- DOOR_CLOSE: if `obstruct`=1, go to DOOR_OPEN. Obstruction overrides expiry.
- MOVE_UP / MOVE_DOWN: at expiry, `etaj_curent` steps by ±1. Then:
  - If the bit for the new floor is pending, clear it and go to DOOR_OPEN.
  - Otherwise stay in the state with the timer cleared.
  - Never step below 0 or above N_FLOORS−1. Such a step cannot occur by construction; assert it.
- DOOR_OPEN: `obstruct`=1 holds the timer at 0. At expiry, go to DOOR_CLOSE if `pending`≠0, else IDLE.
- Simultaneous set and clear of the same bit in the arrival cycle: clear wins, and the request counts as served.
- `reset` has priority over everything, including mid-move. The cabin position is forced to 0; the system integrator re-homes the cabin.

## Timing
- Reset values:
  - state IDLE, `dir` UP, timer 0.
  - `etaj_curent`=0, `pending`=0.
  - `sus`=`jos`=`door_status`=0, `busy`=0.
- Request to `pending` visible: 1 cycle. IDLE to DOOR_CLOSE: 1 cycle after the bit is visible.
- DOOR_CLOSE and DOOR_OPEN each last exactly DOOR_CYCLES cycles when not obstructed. Each floor step lasts exactly MOVE_CYCLES cycles.
- `etaj_curent` and the pending-bit clear update on the same edge as entry to DOOR_OPEN.

## Structure
- Package `elevator_pkg` holds:
  - `state_t` enum (IDLE=3'b000, DOOR_CLOSE=3'b001, MOVE_DOWN=3'b010, MOVE_UP=3'b011, DOOR_OPEN=3'b111).
  - `dir_t` enum.
- Sub-module `elevator_req_scan` (parameter N_FLOORS) is purely combinational. It maps (`pending`, `etaj_curent`) to (`above`, `below`).
- Top level contains the FSM, a single shared timer sized to max(DOOR_CYCLES, MOVE_CYCLES), the position counter and the request bitmap.

## Test plan
- Defaults, at floor 0: `req_floor`=2 at cycle 0.
  - DOOR_CLOSE in cycles 2–5, `sus`=1 in cycles 6–21.
  - `etaj_curent`=1 at cycle 14 and =2 at cycle 22.
  - `door_status`=1 in cycles 22–25, IDLE at 26, `pending`=0.
- SCAN ordering: at floor 3 going up, requests 5, 1, 6 posted together. Service order is 5, 6, 1; `jos` first asserts only after the floor-6 dwell.
- Obstruction: `obstruct`=1 in cycle 2 of DOOR_CLOSE, giving DOOR_OPEN next cycle. Holding `obstruct` for 10 cycles in DOOR_OPEN extends the dwell to 10+DOOR_CYCLES cycles.
- Current-floor request in IDLE at floor 4 gives DOOR_OPEN next cycle with `pending` unchanged. The same request during DOOR_OPEN restarts the dwell.
- Edge cases:
  - `req_floor`=N_FLOORS is ignored.
  - A request for the arrival floor in the arrival cycle leaves the bit cleared.
  - `reset` mid-MOVE_UP gives IDLE, floor 0 and all outputs 0 on the next cycle.
